// File: rtl/video_timing_pkg.sv
// Shared raster-timing types and standard video mode presets.
package video_timing_pkg;

  localparam int unsigned TIMING_FIELD_W = 16;

  typedef logic [TIMING_FIELD_W-1:0] tfield_t;

  typedef struct packed {
    tfield_t h_active;
    tfield_t h_fp;
    tfield_t h_sync;
    tfield_t h_bp;
    tfield_t v_active;
    tfield_t v_fp;
    tfield_t v_sync;
    tfield_t v_bp;
  } timing_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam timing_t TIMING_720P60 = '{
    h_active: 16'd1280, h_fp: 16'd110, h_sync: 16'd40, h_bp: 16'd220,
    v_active: 16'd720,  v_fp: 16'd5,   v_sync: 16'd5,  v_bp: 16'd20
  };

  localparam timing_t TIMING_1080P60 = '{
    h_active: 16'd1920, h_fp: 16'd88, h_sync: 16'd44, h_bp: 16'd148,
    v_active: 16'd1080, v_fp: 16'd4,  v_sync: 16'd5,  v_bp: 16'd36
  };

  localparam timing_t TIMING_640X480 = '{
    h_active: 16'd640, h_fp: 16'd16, h_sync: 16'd96, h_bp: 16'd48,
    v_active: 16'd480, v_fp: 16'd10, v_sync: 16'd2,  v_bp: 16'd33
  };

  function automatic int unsigned h_total(input timing_t t);
    return 32'(t.h_active) + 32'(t.h_fp) + 32'(t.h_sync) + 32'(t.h_bp);
  endfunction

  function automatic int unsigned v_total(input timing_t t);
    return 32'(t.v_active) + 32'(t.v_fp) + 32'(t.v_sync) + 32'(t.v_bp);
  endfunction

endpackage

// File: rtl/video_timing_cnt.sv
// Horizontal/vertical raster counters with active, hsync and vsync window decode.
module video_timing_cnt
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 32'(TIMING_720P60.h_active),
  parameter int unsigned H_FP     = 32'(TIMING_720P60.h_fp),
  parameter int unsigned H_SYNC   = 32'(TIMING_720P60.h_sync),
  parameter int unsigned H_BP     = 32'(TIMING_720P60.h_bp),
  parameter int unsigned V_ACTIVE = 32'(TIMING_720P60.v_active),
  parameter int unsigned V_FP     = 32'(TIMING_720P60.v_fp),
  parameter int unsigned V_SYNC   = 32'(TIMING_720P60.v_sync),
  parameter int unsigned V_BP     = 32'(TIMING_720P60.v_bp)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic act_c,
  output logic hs_a_c,
  output logic vs_a_c,
  output logic frame_end_c
);

  localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW    = (H_TOT > 1) ? $clog2(H_TOT) : 1;
  localparam int unsigned VW    = (V_TOT > 1) ? $clog2(V_TOT) : 1;

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_AEND  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END  = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_AEND  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END  = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic          h_wrap_c, v_wrap_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Counters are held at the origin whenever the raster is not running.
  always_comb begin
    h_wrap_c = (h_cnt_q == H_LAST);
    v_wrap_c = (v_cnt_q == V_LAST);
    h_cnt_d  = '0;
    v_cnt_d  = '0;
    if (run) begin
      h_cnt_d = h_wrap_c ? '0 : h_cnt_q + HW'(1);
      v_cnt_d = v_cnt_q;
      if (h_wrap_c) begin
        v_cnt_d = v_wrap_c ? '0 : v_cnt_q + VW'(1);
      end
    end
    act_c       = run && (h_cnt_q < H_AEND) && (v_cnt_q < V_AEND);
    hs_a_c      = run && (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
    vs_a_c      = run && (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);
    frame_end_c = run && h_wrap_c && v_wrap_c;
  end

endmodule

// File: rtl/video_timing_out.sv
// Raster timing generator that pulls pixels from a FWFT FIFO and drives registered video outputs.
module video_timing_out
  import video_timing_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned H_ACTIVE  = 32'(TIMING_720P60.h_active),
  parameter int unsigned H_FP      = 32'(TIMING_720P60.h_fp),
  parameter int unsigned H_SYNC    = 32'(TIMING_720P60.h_sync),
  parameter int unsigned H_BP      = 32'(TIMING_720P60.h_bp),
  parameter int unsigned V_ACTIVE  = 32'(TIMING_720P60.v_active),
  parameter int unsigned V_FP      = 32'(TIMING_720P60.v_fp),
  parameter int unsigned V_SYNC    = 32'(TIMING_720P60.v_sync),
  parameter int unsigned V_BP      = 32'(TIMING_720P60.v_bp),
  parameter bit          HS_POL    = 1'b1,
  parameter bit          VS_POL    = 1'b1,
  parameter logic [DATA_W-1:0] UFLOW_PIX = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] fifo_rd_data,
  input  logic              fifo_rd_vld,
  output logic              fifo_rd_en,
  output logic              frame_start,
  output logic              vid_hs,
  output logic              vid_vs,
  output logic              vid_de,
  output logic [DATA_W-1:0] vid_data,
  output logic              uflow,
  output logic [15:0]       uflow_cnt,
  input  logic              uflow_clr
);

  localparam int unsigned CNT_W   = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e              state_q, state_d;
  logic                frame_start_q, frame_start_d;
  logic                vid_hs_q, vid_hs_d;
  logic                vid_vs_q, vid_vs_d;
  logic                vid_de_q, vid_de_d;
  logic [DATA_W-1:0]   vid_data_q, vid_data_d;
  logic                uflow_q, uflow_d;
  logic [CNT_W-1:0]    uflow_cnt_q, uflow_cnt_d;
  logic                run_c, act_c, hs_a_c, vs_a_c, frame_end_c;

  assign run_c = (state_q == ST_RUN);

  video_timing_cnt #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_cnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run_c),
    .act_c       (act_c),
    .hs_a_c      (hs_a_c),
    .vs_a_c      (vs_a_c),
    .frame_end_c (frame_end_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      frame_start_q <= 1'b0;
      vid_hs_q      <= ~HS_POL;
      vid_vs_q      <= ~VS_POL;
      vid_de_q      <= 1'b0;
      vid_data_q    <= '0;
      uflow_q       <= 1'b0;
      uflow_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      frame_start_q <= frame_start_d;
      vid_hs_q      <= vid_hs_d;
      vid_vs_q      <= vid_vs_d;
      vid_de_q      <= vid_de_d;
      vid_data_q    <= vid_data_d;
      uflow_q       <= uflow_d;
      uflow_cnt_q   <= uflow_cnt_d;
    end
  end

  // frame_start is raised for the cycle whose counter state will be the frame origin.
  always_comb begin
    state_d       = state_q;
    frame_start_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d       = ST_RUN;
          frame_start_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (frame_end_c) begin
          if (en) begin
            frame_start_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    vid_de_d   = act_c;
    vid_hs_d   = hs_a_c ? HS_POL : ~HS_POL;
    vid_vs_d   = vs_a_c ? VS_POL : ~VS_POL;
    vid_data_d = act_c ? (fifo_rd_vld ? fifo_rd_data : UFLOW_PIX) : '0;

    uflow_d     = uflow_q;
    uflow_cnt_d = uflow_cnt_q;
    if (uflow_clr) begin
      uflow_d     = 1'b0;
      uflow_cnt_d = '0;
    end else if (act_c && !fifo_rd_vld) begin
      uflow_d = 1'b1;
      if (uflow_cnt_q != CNT_MAX) begin
        uflow_cnt_d = uflow_cnt_q + CNT_W'(1);
      end
    end
  end

  // Pops are suppressed while reset is asserted even if the counters still show active video.
  assign fifo_rd_en  = act_c && rst_n;
  assign frame_start = frame_start_q;
  assign vid_hs      = vid_hs_q;
  assign vid_vs      = vid_vs_q;
  assign vid_de      = vid_de_q;
  assign vid_data    = vid_data_q;
  assign uflow       = uflow_q;
  assign uflow_cnt   = uflow_cnt_q;

endmodule
